// File: rtl/nibbler_button_conditioner.sv
// Button front end for the Nibbler core: synchronize, debounce and latch presses on four
// active-low board buttons. Define BUTTON_AUTOREPEAT_EN to add per-button autorepeat events.
module nibbler_button_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
`ifdef BUTTON_AUTOREPEAT_EN
    ,
    parameter int REPEAT_CYCLES   = 16
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rawNotButtons,
    input  logic       readStrobe,
    output logic [3:0] pushbuttons,
    output logic [3:0] pressLatched,
    output logic       anyPress
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0] stable_vec;
    logic [3:0] press_event;
    logic [3:0] latched_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_chan
            logic [SYNC_STAGES-1:0] sync_reg;
            logic [CW-1:0]          cnt_reg;
            logic                   stable_reg;
            logic                   sync_pressed;
            logic                   flip;

            // Last synchronizer stage, inverted to active-high
            assign sync_pressed = ~sync_reg[SYNC_STAGES-1];
            assign flip         = (sync_pressed != stable_reg) && (cnt_reg == CNT_LAST);

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync_reg   <= '1;
                    cnt_reg    <= '0;
                    stable_reg <= 1'b0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], rawNotButtons[gi]};
                    if (sync_pressed == stable_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        stable_reg <= sync_pressed;
                        cnt_reg    <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

`ifdef BUTTON_AUTOREPEAT_EN
            localparam int RW = $clog2(REPEAT_CYCLES + 1);
            localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

            logic [RW-1:0] rep_reg;
            logic          rep_fire;

            assign rep_fire = stable_reg && (rep_reg == REP_LAST);

            always_ff @(posedge clk) begin
                if (reset || !stable_reg || rep_fire) begin
                    rep_reg <= '0;
                end else begin
                    rep_reg <= rep_reg + 1'b1;
                end
            end

            assign press_event[gi] = (flip && sync_pressed) || rep_fire;
`else
            // Only a 0 -> 1 flip of the debounced state is a press
            assign press_event[gi] = flip && sync_pressed;
`endif

            assign stable_vec[gi] = stable_reg;
        end
    endgenerate

    // A press in the same cycle as readStrobe wins so it is never lost
    always_ff @(posedge clk) begin
        if (reset) begin
            latched_reg <= 4'b0000;
        end else begin
            latched_reg <= press_event | (latched_reg & ~{4{readStrobe}});
        end
    end

    assign pushbuttons  = stable_vec;
    assign pressLatched = latched_reg;
    assign anyPress     = |latched_reg;

endmodule

// File: tb/tb_nibbler_button_conditioner.sv
// Directed bench for nibbler_button_conditioner at default parameters.
module tb_nibbler_button_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] rawNotButtons;
    logic       readStrobe;
    logic [3:0] pushbuttons;
    logic [3:0] pressLatched;
    logic       anyPress;

    int n_cmp = 0;
    int n_err = 0;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    always #5 clk = ~clk;

    nibbler_button_conditioner dut (
        .clk          (clk),
        .reset        (reset),
        .rawNotButtons(rawNotButtons),
        .readStrobe   (readStrobe),
        .pushbuttons  (pushbuttons),
        .pressLatched (pressLatched),
        .anyPress     (anyPress)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_all();
        rawNotButtons = 4'b1111;
        repeat (8) tick();
        readStrobe = 1'b1;
        tick();
        readStrobe = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        reset = 1'b1;
        rawNotButtons = 4'b0000;
        readStrobe = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (pushbuttons !== 4'b0000 || pressLatched !== 4'b0000 || anyPress !== 1'b0) begin
                n_err++;
                $display("FAIL reset_state: pb=%b pl=%b any=%b, required 0000/0000/0",
                         pushbuttons, pressLatched, anyPress);
            end
        end
        reset = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            exp = (i == 6) ? 4'b1111 : 4'b0000;
            n_cmp++;
            if (pushbuttons !== exp) begin
                n_err++;
                $display("FAIL reset_release_pb edge %0d: got %b required %b", i, pushbuttons, exp);
            end
        end
        n_cmp++;
        if (pressLatched !== 4'b1111 || anyPress !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_latch: pl=%b any=%b, required 1111/1", pressLatched, anyPress);
        end
        release_all();
        n_cmp++;
        if (pushbuttons !== 4'b0000 || pressLatched !== 4'b0000 || anyPress !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: pb=%b pl=%b any=%b, required 0000/0000/0",
                     pushbuttons, pressLatched, anyPress);
        end
        $display("test_reset done: pb=%b pl=%b", pushbuttons, pressLatched);
    endtask

    task automatic test_press_ack();
        logic [3:0] exp;
        rawNotButtons = 4'b1110;
        for (int i = 1; i <= 6; i++) begin
            tick();
            exp = (i == 6) ? 4'b0001 : 4'b0000;
            n_cmp++;
            if (pushbuttons !== exp) begin
                n_err++;
                $display("FAIL press_latency edge %0d: got %b required %b", i, pushbuttons, exp);
            end
        end
        n_cmp++;
        if (pressLatched !== 4'b0001) begin
            n_err++;
            $display("FAIL press_latch: got %b required 0001", pressLatched);
        end
        readStrobe = 1'b1;
        tick();
        readStrobe = 1'b0;
        n_cmp++;
        if (pressLatched !== 4'b0000 || pushbuttons !== 4'b0001 || anyPress !== 1'b0) begin
            n_err++;
            $display("FAIL ack_clear: pl=%b pb=%b any=%b, required 0000/0001/0",
                     pressLatched, pushbuttons, anyPress);
        end
        release_all();
        n_cmp++;
        if (pushbuttons !== 4'b0000 || pressLatched !== 4'b0000) begin
            n_err++;
            $display("FAIL release_no_event: pb=%b pl=%b, required 0000/0000", pushbuttons, pressLatched);
        end
        $display("test_press_ack done: pb=%b pl=%b", pushbuttons, pressLatched);
    endtask

    task automatic test_bounce();
        for (int h = 0; h < 10; h++) begin
            rawNotButtons = (h % 2 == 0) ? 4'b1101 : 4'b1111;
            for (int c = 0; c < 2; c++) begin
                tick();
                n_cmp++;
                if (pushbuttons !== 4'b0000) begin
                    n_err++;
                    $display("FAIL bounce_pb half %0d: got %b required 0000", h, pushbuttons);
                end
            end
        end
        rawNotButtons = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_cmp++;
            if (pushbuttons !== 4'b0000) begin
                n_err++;
                $display("FAIL bounce_settle cycle %0d: got %b required 0000", c, pushbuttons);
            end
        end
        n_cmp++;
        if (pressLatched !== 4'b0000) begin
            n_err++;
            $display("FAIL bounce_latch: got %b required 0000", pressLatched);
        end
        $display("test_bounce done: pb=%b pl=%b", pushbuttons, pressLatched);
    endtask

    task automatic test_set_wins();
        rawNotButtons = 4'b1110;
        repeat (3) tick();
        rawNotButtons = 4'b1010;
        repeat (5) tick();
        n_cmp++;
        if (pressLatched !== 4'b0001 || pushbuttons !== 4'b0001) begin
            n_err++;
            $display("FAIL set_wins_pre: pl=%b pb=%b, required 0001/0001", pressLatched, pushbuttons);
        end
        readStrobe = 1'b1;
        tick();
        readStrobe = 1'b0;
        n_cmp++;
        if (pressLatched !== 4'b0100 || pushbuttons !== 4'b0101) begin
            n_err++;
            $display("FAIL set_wins: pl=%b pb=%b, required 0100/0101", pressLatched, pushbuttons);
        end
        release_all();
        n_cmp++;
        if (pressLatched !== 4'b0000 || pushbuttons !== 4'b0000) begin
            n_err++;
            $display("FAIL set_wins_idle: pl=%b pb=%b, required 0000/0000", pressLatched, pushbuttons);
        end
        $display("test_set_wins done: pb=%b pl=%b", pushbuttons, pressLatched);
    endtask

    task automatic test_reset_midcount();
        logic [3:0] exp;
        rawNotButtons = 4'b0111;
        repeat (5) tick();
        n_cmp++;
        if (pushbuttons !== 4'b0000) begin
            n_err++;
            $display("FAIL midcount_pre: got %b required 0000", pushbuttons);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (pushbuttons !== 4'b0000 || pressLatched !== 4'b0000) begin
            n_err++;
            $display("FAIL midcount_reset: pb=%b pl=%b, required 0000/0000", pushbuttons, pressLatched);
        end
        for (int i = 1; i <= 6; i++) begin
            tick();
            exp = (i == 6) ? 4'b1000 : 4'b0000;
            n_cmp++;
            if (pushbuttons !== exp) begin
                n_err++;
                $display("FAIL midcount_relatency edge %0d: got %b required %b", i, pushbuttons, exp);
            end
        end
        n_cmp++;
        if (pressLatched !== 4'b1000) begin
            n_err++;
            $display("FAIL midcount_latch: got %b required 1000", pressLatched);
        end
        release_all();
        $display("test_reset_midcount done: pb=%b pl=%b", pushbuttons, pressLatched);
    endtask

    task automatic test_autorepeat();
        logic exp;
        int   pulses;
        pulses = 0;
        rawNotButtons = 4'b1110;
        repeat (6) tick();
        n_cmp++;
        if (pressLatched !== 4'b0001) begin
            n_err++;
            $display("FAIL repeat_first: got %b required 0001", pressLatched);
        end
        readStrobe = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            tick();
            exp = AUTOREP && (k % 16 == 0);
            if (pressLatched[0]) pulses++;
            n_cmp++;
            if (pressLatched[0] !== exp || pushbuttons !== 4'b0001) begin
                n_err++;
                $display("FAIL repeat_cycle %0d: pl0=%b pb=%b, required %b/0001",
                         k, pressLatched[0], pushbuttons, exp);
            end
        end
        readStrobe = 1'b0;
        release_all();
        n_cmp++;
        if (pressLatched !== 4'b0000 || pushbuttons !== 4'b0000) begin
            n_err++;
            $display("FAIL repeat_idle: pl=%b pb=%b, required 0000/0000", pressLatched, pushbuttons);
        end
        $display("test_autorepeat done: extra pulses=%0d", pulses);
    endtask

    initial begin
        test_reset();
        test_press_ack();
        test_bounce();
        test_set_wins();
        test_reset_midcount();
        test_autorepeat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
